// File: rtl/bp_me_lce_out_arbiter.sv
// Merges an LCE's outbound request and response channels onto one registered link.
// Responses win by default; a starvation counter forces a request through after max_starve_p losses.
module bp_me_lce_out_arbiter #(
    parameter int link_width_p = 128,
    parameter int max_starve_p = 4,
    localparam int starve_width_lp = (max_starve_p < 1) ? 1 : $clog2(max_starve_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic [link_width_p-1:0]    lce_req_i,
    input  logic                       lce_req_v_i,
    output logic                       lce_req_ready_o,

    input  logic [link_width_p-1:0]    lce_resp_i,
    input  logic                       lce_resp_v_i,
    output logic                       lce_resp_ready_o,

    output logic [link_width_p-1:0]    link_o,
    output logic                       link_sel_o,
    output logic                       link_v_o,
    input  logic                       link_ready_i,

    output logic [starve_width_lp-1:0] starve_cnt_o
);

    typedef enum logic {e_empty, e_full} state_e;

    state_e                     state_r, state_n;
    logic [link_width_p-1:0]    link_r;
    logic                       sel_r;
    logic [starve_width_lp-1:0] starve_cnt_r;

    logic slot_free, starved, req_wins, any_v;

    // Ready is forced low during reset so no handshake can complete in a reset cycle.
    assign slot_free = reset_n_i & ((state_r == e_empty) | link_ready_i);
    assign starved   = (starve_cnt_r == starve_width_lp'(max_starve_p));
    assign req_wins  = lce_req_v_i & (~lce_resp_v_i | starved);
    assign any_v     = lce_req_v_i | lce_resp_v_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_r <= e_empty;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        if (slot_free) state_n = any_v ? e_full : e_empty;
    end

    always_comb begin
        link_v_o         = (state_r == e_full);
        lce_req_ready_o  = slot_free & req_wins;
        lce_resp_ready_o = slot_free & ~req_wins;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            link_r       <= '0;
            sel_r        <= 1'b0;
            starve_cnt_r <= '0;
        end else if (slot_free) begin
            if (any_v) begin
                link_r <= req_wins ? lce_req_i : lce_resp_i;
                sel_r  <= ~req_wins;
            end
            // A pending request that loses counts up; anything else clears the count.
            if (lce_req_v_i & ~req_wins) starve_cnt_r <= starve_cnt_r + starve_width_lp'(1);
            else                         starve_cnt_r <= '0;
        end
    end

    assign link_o       = link_r;
    assign link_sel_o   = sel_r;
    assign starve_cnt_o = starve_cnt_r;

`ifndef SYNTHESIS
    a_hold_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (link_v_o && !link_ready_i) |=> (link_v_o && $stable(link_o) && $stable(link_sel_o)));
    a_one_grant: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(lce_req_ready_o && lce_req_v_i && lce_resp_ready_o && lce_resp_v_i));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        starve_cnt_o <= starve_width_lp'(max_starve_p));
`endif

endmodule

// File: tb/tb_bp_me_lce_out_arbiter.sv
// Directed bench for bp_me_lce_out_arbiter: scoreboard of expected link transfers plus
// immediate checks of ready, starvation count and hold behaviour; a second instance uses max_starve_p=0.
module tb_bp_me_lce_out_arbiter;
    localparam int W = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [W-1:0] req, resp;
    logic         req_v, resp_v, lr;

    logic         req_rdy0, resp_rdy0, sel0, v0;
    logic [W-1:0] link0;
    logic [2:0]   cnt0;
    logic         req_rdy1, resp_rdy1, sel1, v1;
    logic [W-1:0] link1;
    logic [0:0]   cnt1;

    bp_me_lce_out_arbiter #(.link_width_p(W), .max_starve_p(4)) u_dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .lce_req_i(req), .lce_req_v_i(req_v), .lce_req_ready_o(req_rdy0),
        .lce_resp_i(resp), .lce_resp_v_i(resp_v), .lce_resp_ready_o(resp_rdy0),
        .link_o(link0), .link_sel_o(sel0), .link_v_o(v0), .link_ready_i(lr),
        .starve_cnt_o(cnt0));

    bp_me_lce_out_arbiter #(.link_width_p(W), .max_starve_p(0)) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n),
        .lce_req_i(req), .lce_req_v_i(req_v), .lce_req_ready_o(req_rdy1),
        .lce_resp_i(resp), .lce_resp_v_i(resp_v), .lce_resp_ready_o(resp_rdy1),
        .link_o(link1), .link_sel_o(sel1), .link_v_o(v1), .link_ready_i(lr),
        .starve_cnt_o(cnt1));

    typedef struct packed {
        logic         sel;
        logic [W-1:0] data;
    } msg_t;

    msg_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic s, input logic [W-1:0] d);
        msg_t m;
        m.sel  = s;
        m.data = d;
        sb.push_back(m);
    endtask

    // A transfer leaves the link whenever valid meets ready outside reset.
    task automatic mon();
        msg_t e;
        if (mon_en && rst_n && v0 && lr) begin
            chk("sb_nonempty", W'(sb.size() != 0), W'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("link_data", link0, e.data);
                chk("link_sel", W'(sel0), W'(e.sel));
            end
        end
    endtask

    // Inputs change 1 after the edge; everything is sampled 2 after the edge.
    task automatic cyc(input logic r, input logic rv, input logic [W-1:0] rd,
                       input logic sv, input logic [W-1:0] sd, input logic l);
        @(posedge clk);
        #1;
        rst_n = r; req_v = rv; req = rd; resp_v = sv; resp = sd; lr = l;
        #1;
        mon();
    endtask

    initial begin
        int k, rn, sn;
        rst_n = 1'b0; req_v = 1'b1; resp_v = 1'b1; req = W'('hB0); resp = W'('hA0); lr = 1'b1;
        mon_en = 1'b1;

        // Reset held with both channels valid
        repeat (3) begin
            cyc(1'b0, 1'b1, W'('hB0), 1'b1, W'('hA0), 1'b1);
            chk("rst_v", W'(v0), W'(0));
            chk("rst_link", link0, W'(0));
            chk("rst_sel", W'(sel0), W'(0));
            chk("rst_cnt", W'(cnt0), W'(0));
            chk("rst_req_rdy", W'(req_rdy0), W'(0));
            chk("rst_resp_rdy", W'(resp_rdy0), W'(0));
        end

        // Release: response wins first
        push(1'b1, W'('hA1));
        cyc(1'b1, 1'b1, W'('hB1), 1'b1, W'('hA1), 1'b1);
        chk("rel_resp_rdy", W'(resp_rdy0), W'(1));
        chk("rel_req_rdy", W'(req_rdy0), W'(0));
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("rel_v", W'(v0), W'(1));
        chk("rel_cnt", W'(cnt0), W'(1));
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("rel_drain_v", W'(v0), W'(0));
        chk("rel_drain_cnt", W'(cnt0), W'(0));

        // Request-only streaming, no bubbles
        for (int i = 1; i <= 8; i++) begin
            push(1'b0, W'(i));
            cyc(1'b1, 1'b1, W'(i), 1'b0, W'(0), 1'b1);
            chk("str_req_rdy", W'(req_rdy0), W'(1));
            if (i > 1) chk("str_v", W'(v0), W'(1));
        end
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("str_last_v", W'(v0), W'(1));
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("str_idle_v", W'(v0), W'(0));

        // Starvation: both valid continuously, request forced through every fifth grant
        k = 0; rn = 0; sn = 0;
        for (int g = 0; g < 10; g++) begin
            if (k == 4) push(1'b0, W'(32'h200 + rn));
            else        push(1'b1, W'(32'h100 + sn));
            cyc(1'b1, 1'b1, W'(32'h200 + rn), 1'b1, W'(32'h100 + sn), 1'b1);
            chk("stv_cnt", W'(cnt0), W'(k));
            chk("stv_req_rdy", W'(req_rdy0), W'(k == 4));
            chk("stv_resp_rdy", W'(resp_rdy0), W'(k != 4));
            if (k == 4) begin rn++; k = 0; end
            else        begin sn++; k++;   end
        end
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("stv_last_v", W'(v0), W'(1));
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("stv_idle_v", W'(v0), W'(0));
        chk("stv_idle_cnt", W'(cnt0), W'(0));

        // Backpressure: link held stable, readies low, count frozen
        push(1'b1, W'('h110));
        cyc(1'b1, 1'b1, W'('h210), 1'b1, W'('h110), 1'b1);
        chk("bp_grant", W'(resp_rdy0), W'(1));
        repeat (5) begin
            cyc(1'b1, 1'b1, W'('h210), 1'b1, W'('h111), 1'b0);
            chk("bp_v", W'(v0), W'(1));
            chk("bp_link", link0, W'('h110));
            chk("bp_sel", W'(sel0), W'(1));
            chk("bp_req_rdy", W'(req_rdy0), W'(0));
            chk("bp_resp_rdy", W'(resp_rdy0), W'(0));
            chk("bp_cnt", W'(cnt0), W'(1));
        end
        push(1'b1, W'('h111));
        cyc(1'b1, 1'b1, W'('h210), 1'b1, W'('h111), 1'b1);
        chk("bp_reload_rdy", W'(resp_rdy0), W'(1));
        chk("bp_reload_cnt", W'(cnt0), W'(1));
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("bp_drain_cnt", W'(cnt0), W'(2));
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("bp_idle_v", W'(v0), W'(0));

        // Reset while full with count 3
        for (int i = 0; i < 3; i++) begin
            push(1'b1, W'(32'h120 + i));
            cyc(1'b1, 1'b1, W'('h220), 1'b1, W'(32'h120 + i), 1'b1);
        end
        cyc(1'b0, 1'b1, W'('h220), 1'b1, W'('h123), 1'b1);
        chk("mrst_cnt_before", W'(cnt0), W'(3));
        chk("mrst_v_before", W'(v0), W'(1));
        chk("mrst_req_rdy", W'(req_rdy0), W'(0));
        chk("mrst_resp_rdy", W'(resp_rdy0), W'(0));
        chk("mrst_sb_held", W'(sb.size()), W'(1));
        sb.delete();
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("mrst_v", W'(v0), W'(0));
        chk("mrst_cnt", W'(cnt0), W'(0));
        chk("mrst_link", link0, W'(0));

        // max_starve_p=0 instance: request always wins when valid
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, W'(32'h300 + i), 1'b1, W'('h400), 1'b1);
            chk("ms0_req_rdy", W'(req_rdy1), W'(1));
            chk("ms0_resp_rdy", W'(resp_rdy1), W'(0));
            chk("ms0_cnt", W'(cnt1), W'(0));
            if (i > 0) begin
                chk("ms0_sel", W'(sel1), W'(0));
                chk("ms0_link", link1, W'(32'h300 + i - 1));
            end
        end
        cyc(1'b1, 1'b0, W'(0), 1'b1, W'('h400), 1'b1);
        chk("ms0_resp_only_rdy", W'(resp_rdy1), W'(1));
        chk("ms0_req_rdy_off", W'(req_rdy1), W'(0));
        chk("ms0_link_last_req", link1, W'('h303));
        cyc(1'b1, 1'b0, W'(0), 1'b0, W'(0), 1'b1);
        chk("ms0_resp_v", W'(v1), W'(1));
        chk("ms0_resp_sel", W'(sel1), W'(1));
        chk("ms0_resp_link", link1, W'('h400));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
